clock_heartbeat_monitor: RTL and testbench

Single-clock liveness and rate checker for a monitored clock.
- The monitored domain divides its clock into a toggling heartbeat, synchronised into this domain by the standard synchronizer.
- This block measures reference cycles between heartbeat edges and flags loss or overspeed.
- clock_good is the health status that drives the select of a downstream glitch-free clock multiplexer (fallback when low).

---
 rtl/clock_heartbeat_monitor_if.sv | 25 ++
 rtl/clock_heartbeat_monitor.sv | 183 ++++++++++++++++++
 tb/tb_clock_heartbeat_monitor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_heartbeat_monitor_if.sv
// Control and status bundle between a heartbeat monitor and its user.
interface clock_heartbeat_monitor_if #(
  parameter int unsigned COUNTER_WIDTH = 16
);
  logic                     enable;
  logic                     heartbeat;
  logic                     fail_clear;
  logic                     clock_good;
  logic                     clock_failed;
  logic                     fail_event;
  logic [COUNTER_WIDTH-1:0] period_value;
  logic                     period_valid;

  // User side: drives controls and the synchronised heartbeat, observes status
  modport master (
    output enable, heartbeat, fail_clear,
    input  clock_good, clock_failed, fail_event, period_value, period_valid
  );

  // Monitor side
  modport slave (
    input  enable, heartbeat, fail_clear,
    output clock_good, clock_failed, fail_event, period_value, period_valid
  );
endinterface

// File: rtl/clock_heartbeat_monitor.sv
// Liveness and rate checker: counts reference cycles between heartbeat edges,
// flags loss (timeout) or overspeed, and reports clock health for a clock mux.
module clock_heartbeat_monitor #(
  parameter int unsigned COUNTER_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 64,
  parameter int unsigned MIN_PERIOD       = 4,
  parameter int unsigned RECOVERY_PERIODS = 4,
  parameter bit          AUTO_RECOVER     = 1'b1
) (
  input  logic                      clock,
  input  logic                      resetn,
  clock_heartbeat_monitor_if.slave  mon
);

  localparam int unsigned CW     = COUNTER_WIDTH;
  localparam int unsigned GOOD_W = $clog2(RECOVERY_PERIODS + 1);

  localparam logic [CW-1:0]     CNT_MAX      = '1;
  localparam logic [CW-1:0]     TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]     TIMEOUT_P    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]     MIN_P        = CW'(MIN_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_TARGET  = GOOD_W'(RECOVERY_PERIODS);
  localparam logic [GOOD_W-1:0] GOOD_MAX     = GOOD_TARGET;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STARTUP = 2'd1,
    ST_GOOD    = 2'd2,
    ST_FAILED  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CW-1:0]       counter, counter_next;
  logic [GOOD_W-1:0]   good_count, good_count_next;
  logic                sync_pending, sync_pending_next;
  logic                heartbeat_q;

  logic [CW-1:0]       period_value_next;
  logic                period_valid_next;
  logic                fail_event_next;
  logic                clock_good_next;
  logic                clock_failed_next;

  logic                hb_edge_c;
  logic                timeout_c;
  logic [CW-1:0]       measured_c;
  logic                good_period_c;
  logic [GOOD_W-1:0]   good_inc_c;

  // Edge detect, saturating measurement and period classification
  always_comb begin
    hb_edge_c     = mon.heartbeat ^ heartbeat_q;
    measured_c    = (counter == CNT_MAX) ? counter : counter + 1'b1;
    good_period_c = (measured_c >= MIN_P) && (measured_c <= TIMEOUT_P);
    timeout_c     = !hb_edge_c && (counter == TIMEOUT_LAST);
    good_inc_c    = (good_count == GOOD_MAX) ? good_count : good_count + 1'b1;
  end

  // Next-state, counters and registered-output values
  always_comb begin
    state_next        = state;
    counter_next      = hb_edge_c ? '0 : measured_c;
    good_count_next   = good_count;
    sync_pending_next = sync_pending;
    period_value_next = mon.period_value;
    period_valid_next = 1'b0;

    if (state == ST_IDLE) begin
      counter_next    = '0;
      good_count_next = '0;
      if (mon.enable) begin
        state_next        = ST_STARTUP;
        sync_pending_next = 1'b1;
      end
    end else if (!mon.enable) begin
      state_next        = ST_IDLE;
      counter_next      = '0;
      good_count_next   = '0;
      sync_pending_next = 1'b0;
    end else begin
      unique case (state)
        ST_STARTUP: begin
          if (sync_pending) begin
            // First edge only aligns the counter to the heartbeat phase
            if (hb_edge_c) begin
              sync_pending_next = 1'b0;
            end else if (timeout_c) begin
              state_next      = ST_FAILED;
              good_count_next = '0;
            end
          end else if (hb_edge_c) begin
            period_valid_next = 1'b1;
            period_value_next = measured_c;
            if (good_period_c) begin
              good_count_next = good_inc_c;
              if (good_inc_c == GOOD_TARGET) begin
                state_next = ST_GOOD;
              end
            end else begin
              state_next      = ST_FAILED;
              good_count_next = '0;
            end
          end else if (timeout_c) begin
            state_next      = ST_FAILED;
            good_count_next = '0;
          end
        end

        ST_GOOD: begin
          if (hb_edge_c) begin
            period_valid_next = 1'b1;
            period_value_next = measured_c;
            if (!good_period_c) begin
              state_next      = ST_FAILED;
              good_count_next = '0;
            end
          end else if (timeout_c) begin
            state_next      = ST_FAILED;
            good_count_next = '0;
          end
        end

        ST_FAILED: begin
          if (mon.fail_clear) begin
            // Restart from scratch; the saturated counter must not mask a timeout
            state_next        = ST_STARTUP;
            sync_pending_next = 1'b1;
            counter_next      = '0;
            good_count_next   = '0;
          end else if (hb_edge_c) begin
            period_valid_next = 1'b1;
            period_value_next = measured_c;
            if (good_period_c) begin
              good_count_next = good_inc_c;
              if (AUTO_RECOVER && (good_inc_c == GOOD_TARGET)) begin
                state_next = ST_GOOD;
              end
            end else begin
              good_count_next = '0;
            end
          end else if (timeout_c) begin
            good_count_next = '0;
          end
        end

        default: begin
        end
      endcase
    end

    clock_good_next   = (state_next == ST_GOOD);
    clock_failed_next = (state_next == ST_FAILED);
    fail_event_next   = (state_next == ST_FAILED) && (state != ST_FAILED);
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      counter          <= '0;
      good_count       <= '0;
      sync_pending     <= 1'b0;
      heartbeat_q      <= 1'b0;
      mon.clock_good   <= 1'b0;
      mon.clock_failed <= 1'b0;
      mon.fail_event   <= 1'b0;
      mon.period_value <= '0;
      mon.period_valid <= 1'b0;
    end else begin
      state            <= state_next;
      counter          <= counter_next;
      good_count       <= good_count_next;
      sync_pending     <= sync_pending_next;
      heartbeat_q      <= mon.heartbeat;
      mon.clock_good   <= clock_good_next;
      mon.clock_failed <= clock_failed_next;
      mon.fail_event   <= fail_event_next;
      mon.period_value <= period_value_next;
      mon.period_valid <= period_valid_next;
    end
  end

endmodule

// File: tb/tb_clock_heartbeat_monitor.sv
// Directed bench for clock_heartbeat_monitor: one auto-recovering and one
// sticky instance driven by the same heartbeat, enable and fail_clear.
module tb_clock_heartbeat_monitor;

  localparam int unsigned CW = 16;

  logic clock = 1'b0;
  logic resetn;
  logic enable;
  logic heartbeat;
  logic fail_clear;
  logic fe_seen;

  int checks   = 0;
  int failures = 0;

  // 10 ns reference clock
  always #5 clock = ~clock;

  clock_heartbeat_monitor_if #(.COUNTER_WIDTH(CW)) if_a ();
  clock_heartbeat_monitor_if #(.COUNTER_WIDTH(CW)) if_b ();

  assign if_a.enable     = enable;
  assign if_a.heartbeat  = heartbeat;
  assign if_a.fail_clear = fail_clear;
  assign if_b.enable     = enable;
  assign if_b.heartbeat  = heartbeat;
  assign if_b.fail_clear = fail_clear;

  clock_heartbeat_monitor #(
    .COUNTER_WIDTH(CW), .TIMEOUT_CYCLES(64), .MIN_PERIOD(4),
    .RECOVERY_PERIODS(4), .AUTO_RECOVER(1'b1)
  ) dut_a (
    .clock  (clock),
    .resetn (resetn),
    .mon    (if_a)
  );

  clock_heartbeat_monitor #(
    .COUNTER_WIDTH(CW), .TIMEOUT_CYCLES(64), .MIN_PERIOD(4),
    .RECOVERY_PERIODS(4), .AUTO_RECOVER(1'b0)
  ) dut_b (
    .clock  (clock),
    .resetn (resetn),
    .mon    (if_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Toggle heartbeat; after return the outputs show that edge's evaluation
  task automatic hb_edge();
    heartbeat = ~heartbeat;
    step();
  endtask

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    enable     = 1'b0;
    heartbeat  = 1'b0;
    fail_clear = 1'b0;
    fe_seen    = 1'b0;

    // Reset state
    idle(3);
    check_eq("rst_good_a",   32'(if_a.clock_good),   0);
    check_eq("rst_failed_a", 32'(if_a.clock_failed), 0);
    check_eq("rst_fe_a",     32'(if_a.fail_event),   0);
    check_eq("rst_pvalue_a", 32'(if_a.period_value), 0);
    check_eq("rst_pvalid_a", 32'(if_a.period_valid), 0);
    resetn = 1'b1;
    idle(2);
    check_eq("idle_good_a", 32'(if_a.clock_good), 0);

    // Startup with period 10: sync edge, then GOOD on the 4th good period
    enable = 1'b1;
    step();
    idle(3);
    hb_edge();
    check_eq("sync_pvalid_a", 32'(if_a.period_valid), 0);
    idle(9);
    hb_edge();
    check_eq("p1_pvalid_a", 32'(if_a.period_valid), 1);
    check_eq("p1_value_a",  32'(if_a.period_value), 10);
    check_eq("p1_good_a",   32'(if_a.clock_good),   0);
    repeat (2) begin
      idle(9);
      hb_edge();
    end
    check_eq("p3_good_a", 32'(if_a.clock_good), 0);
    idle(9);
    hb_edge();
    check_eq("p4_good_a",   32'(if_a.clock_good),   1);
    check_eq("p4_failed_a", 32'(if_a.clock_failed), 0);
    check_eq("p4_good_b",   32'(if_b.clock_good),   1);

    // Loss: failure exactly 64 cycles after the last edge
    idle(63);
    check_eq("loss63_good_a", 32'(if_a.clock_good), 1);
    check_eq("loss63_fe_a",   32'(if_a.fail_event), 0);
    step();
    check_eq("loss64_fe_a",     32'(if_a.fail_event),   1);
    check_eq("loss64_good_a",   32'(if_a.clock_good),   0);
    check_eq("loss64_failed_a", 32'(if_a.clock_failed), 1);
    check_eq("loss64_failed_b", 32'(if_b.clock_failed), 1);
    step();
    check_eq("loss65_fe_a", 32'(if_a.fail_event), 0);
    fe_seen = 1'b0;
    repeat (20) begin
      step();
      fe_seen = fe_seen | if_a.fail_event;
    end
    check_eq("loss_no_refire_a", 32'(fe_seen), 0);

    // Recovery: first edge 86 cycles after the last one is slow
    hb_edge();
    check_eq("rec_slow_pvalid_a", 32'(if_a.period_valid), 1);
    check_eq("rec_slow_value_a",  32'(if_a.period_value), 86);
    check_eq("rec_slow_failed_a", 32'(if_a.clock_failed), 1);
    repeat (3) begin
      idle(9);
      hb_edge();
    end
    check_eq("rec3_good_a", 32'(if_a.clock_good), 0);
    idle(9);
    hb_edge();
    check_eq("rec4_good_a",   32'(if_a.clock_good),   1);
    check_eq("rec4_failed_a", 32'(if_a.clock_failed), 0);
    check_eq("rec4_failed_b", 32'(if_b.clock_failed), 1);
    check_eq("rec4_good_b",   32'(if_b.clock_good),   0);

    // fail_clear restarts the sticky instance, ignored in GOOD
    fail_clear = 1'b1;
    step();
    fail_clear = 1'b0;
    check_eq("clr_failed_b", 32'(if_b.clock_failed), 0);
    check_eq("clr_good_b",   32'(if_b.clock_good),   0);
    check_eq("clr_good_a",   32'(if_a.clock_good),   1);
    idle(8);
    hb_edge();
    check_eq("clr_sync_pvalid_b", 32'(if_b.period_valid), 0);
    check_eq("clr_pvalid_a",      32'(if_a.period_valid), 1);
    check_eq("clr_value_a",       32'(if_a.period_value), 10);
    repeat (3) begin
      idle(9);
      hb_edge();
    end
    check_eq("clr3_good_b", 32'(if_b.clock_good), 0);
    idle(9);
    hb_edge();
    check_eq("clr4_good_b", 32'(if_b.clock_good), 1);

    // Edge in the exact timeout cycle: period 64 stays good
    idle(63);
    hb_edge();
    check_eq("p64_value_a",  32'(if_a.period_value), 64);
    check_eq("p64_good_a",   32'(if_a.clock_good),   1);
    check_eq("p64_failed_a", 32'(if_a.clock_failed), 0);
    check_eq("p64_good_b",   32'(if_b.clock_good),   1);

    // MIN_PERIOD boundary: 4 keeps GOOD, 3 fails
    idle(3);
    hb_edge();
    check_eq("p4c_value_a", 32'(if_a.period_value), 4);
    check_eq("p4c_good_a",  32'(if_a.clock_good),   1);
    idle(2);
    hb_edge();
    check_eq("p3c_value_a",  32'(if_a.period_value), 3);
    check_eq("p3c_failed_a", 32'(if_a.clock_failed), 1);
    check_eq("p3c_fe_a",     32'(if_a.fail_event),   1);
    check_eq("p3c_failed_b", 32'(if_b.clock_failed), 1);
    step();
    check_eq("p3c_fe_drop_a", 32'(if_a.fail_event), 0);

    // Four good periods recover A; B stays failed
    idle(8);
    hb_edge();
    check_eq("r1_value_a",  32'(if_a.period_value), 10);
    check_eq("r1_failed_a", 32'(if_a.clock_failed), 1);
    repeat (2) begin
      idle(9);
      hb_edge();
    end
    idle(9);
    hb_edge();
    check_eq("r4_good_a",   32'(if_a.clock_good),   1);
    check_eq("r4_failed_b", 32'(if_b.clock_failed), 1);

    // Period 2 fails from GOOD
    idle(1);
    hb_edge();
    check_eq("p2_value_a",  32'(if_a.period_value), 2);
    check_eq("p2_fe_a",     32'(if_a.fail_event),   1);
    check_eq("p2_failed_a", 32'(if_a.clock_failed), 1);
    check_eq("p2_good_a",   32'(if_a.clock_good),   0);
    step();
    check_eq("p2_fe_drop_a", 32'(if_a.fail_event), 0);

    // enable low wins over fail_clear: IDLE, no status, no measurements
    enable     = 1'b0;
    fail_clear = 1'b1;
    step();
    fail_clear = 1'b0;
    check_eq("dis_good_a",   32'(if_a.clock_good),   0);
    check_eq("dis_failed_a", 32'(if_a.clock_failed), 0);
    check_eq("dis_failed_b", 32'(if_b.clock_failed), 0);
    check_eq("dis_good_b",   32'(if_b.clock_good),   0);
    idle(3);
    hb_edge();
    idle(9);
    hb_edge();
    check_eq("dis_pvalid_b", 32'(if_b.period_valid), 0);

    // Async reset mid-GOOD
    enable = 1'b1;
    step();
    hb_edge();
    repeat (4) begin
      idle(9);
      hb_edge();
    end
    check_eq("pre_rst_good_a", 32'(if_a.clock_good), 1);
    check_eq("pre_rst_good_b", 32'(if_b.clock_good), 1);
    idle(2);
    resetn = 1'b0;
    #1;
    check_eq("arst_good_a",   32'(if_a.clock_good),   0);
    check_eq("arst_pvalue_a", 32'(if_a.period_value), 0);
    check_eq("arst_good_b",   32'(if_b.clock_good),   0);
    #2;
    resetn = 1'b1;

    // Startup sequence repeats after release
    step();
    hb_edge();
    check_eq("rs_sync_pvalid_a", 32'(if_a.period_valid), 0);
    idle(9);
    hb_edge();
    check_eq("rs_p1_pvalid_a", 32'(if_a.period_valid), 1);
    check_eq("rs_p1_value_a",  32'(if_a.period_value), 10);
    check_eq("rs_p1_good_a",   32'(if_a.clock_good),   0);
    repeat (2) begin
      idle(9);
      hb_edge();
    end
    idle(9);
    hb_edge();
    check_eq("rs_p4_good_a", 32'(if_a.clock_good), 1);

    // Async reset mid-FAILED, while fail_event is high
    idle(63);
    step();
    check_eq("pre_rst2_failed_a", 32'(if_a.clock_failed), 1);
    check_eq("pre_rst2_fe_a",     32'(if_a.fail_event),   1);
    resetn = 1'b0;
    #1;
    check_eq("arst2_failed_a", 32'(if_a.clock_failed), 0);
    check_eq("arst2_fe_a",     32'(if_a.fail_event),   0);
    check_eq("arst2_pvalue_a", 32'(if_a.period_value), 0);
    #2;
    resetn = 1'b1;
    idle(2);
    check_eq("post_rst2_failed_a", 32'(if_a.clock_failed), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
